// File: rtl/s2p_receiver_pkg.sv
// s2p_receiver_pkg: shared types and constants for the serial-to-parallel receiver.
// Build option: define S2P_PARITY_EN to expect one even-parity bit after the data bits.
package s2p_receiver_pkg;

    // Receiver FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    // Number of strobes per frame beyond the data bits
`ifdef S2P_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: WIDTH-bit serial-in shift register with synchronous clear.
// MSB_FIRST=1 shifts left (new bit into bit 0); MSB_FIRST=0 shifts right (new bit into the MSB).
// word_o is the value the register takes at the next edge when not cleared, so the owner can
// capture a completed word on the same cycle as its final bit.
module s2p_shift_reg #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {data_q[WIDTH-2:0], bit_i};
        end else begin : g_lsb_first
            assign shifted = {bit_i, data_q[WIDTH-1:1]};
        end
    endgenerate

    // Next contents: shift on enable, clear wins over everything
    always_comb begin
        word_o = shift_i ? shifted : data_q;
        data_d = clr_i ? '0 : word_o;
    end

    // Register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) data_q <= '0;
        else          data_q <= data_d;
    end

endmodule

// File: rtl/s2p_receiver.sv
// s2p_receiver: receive end of the serial link. Collects one word per frame, one bit per
// strobe, and presents it on a valid/ready parallel port.
// Build option: define S2P_PARITY_EN for a trailing even-parity bit and a live parity_err.
// Handshake: par_valid stays high with par_data stable until a cycle with par_valid & par_ready;
// a word finishing while the port is still full is dropped and flagged via sticky overrun.
module s2p_receiver
    import s2p_receiver_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_frame,
    input  logic             s_bit_en,
    input  logic             s_data,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output state_t           dbg_state
);

    localparam int            NBITS    = WIDTH + PARITY_BITS;
    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);
    localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] par_data_q, par_data_d;
    logic             par_valid_q, par_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             strobe, take, last, abort, commit;
    logic             sr_clr, sr_shift;
    logic [WIDTH-1:0] sr_word;

    // Frame events: an accepted bit, the final bit, and an early frame drop
    always_comb begin
        strobe   = s_frame & s_bit_en;
        take     = strobe & ((state_q == ST_IDLE) | (state_q == ST_SHIFT));
        last     = take & (cnt_q == LAST_CNT);
        abort    = (state_q == ST_SHIFT) & ~s_frame;
        sr_shift = take & (cnt_q < DATA_CNT);
        sr_clr   = abort | ((state_q == ST_WAIT_END) & ~s_frame);
        commit   = last & (~par_valid_q | par_ready);
    end

    s2p_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (sr_clr),
        .shift_i (sr_shift),
        .bit_i   (s_data),
        .word_o  (sr_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (strobe) state_d = last ? ST_WAIT_END : ST_SHIFT;
            ST_SHIFT:    if (!s_frame) state_d = ST_IDLE;
                         else if (last) state_d = ST_WAIT_END;
            ST_WAIT_END: if (!s_frame) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == ST_SHIFT) | (state_q == ST_WAIT_END);
        dbg_state = state_q;
    end

    // Bit counter and output-port next values
    always_comb begin
        cnt_d = cnt_q;
        if (sr_clr || last) cnt_d = '0;
        else if (take)      cnt_d = cnt_q + CW'(1);

        par_data_d  = par_data_q;
        par_valid_d = par_valid_q;
        if (commit) begin
            par_data_d  = sr_word;
            par_valid_d = 1'b1;
        end else if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end

        frame_err_d = abort;
        overrun_d   = overrun_q | (last & ~commit);
    end

    // Counter, output port and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef S2P_PARITY_EN
    logic parity_err_q, parity_err_d;

    // The final strobe carries the parity bit; the data bits are already complete in sr_word
    always_comb begin
        parity_err_d = parity_err_q;
        if (commit) parity_err_d = (^sr_word) ^ s_data;
    end

    // Parity result travels with the word it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign par_data  = par_data_q;
    assign par_valid = par_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_s2p_receiver.sv
// tb_s2p_receiver: drives one serial stream into an MSB-first and an LSB-first receiver and
// checks both every cycle against a bit-list model, plus hand-computed literal expectations.
module tb_s2p_receiver;
    import s2p_receiver_pkg::*;

    localparam int W = 32;
`ifdef S2P_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic clk;
    logic rst_n, s_frame, s_bit_en, s_data, par_ready;

    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l;
    logic         ovr_m, ovr_l, perr_m, perr_l;
    state_t       st_m, st_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    s2p_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_frame(s_frame), .s_bit_en(s_bit_en), .s_data(s_data),
        .par_data(data_m), .par_valid(valid_m), .par_ready(par_ready), .busy(busy_m),
        .frame_err(ferr_m), .overrun(ovr_m), .parity_err(perr_m), .dbg_state(st_m)
    );

    s2p_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_frame(s_frame), .s_bit_en(s_bit_en), .s_data(s_data),
        .par_data(data_l), .par_valid(valid_l), .par_ready(par_ready), .busy(busy_l),
        .frame_err(ferr_l), .overrun(ovr_l), .parity_err(perr_l), .dbg_state(st_l)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit rand_ready = 1'b0;
    int gap_max  = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a list of received bits; once it holds NB bits the word is packed from it.
    bit           q_bits[$];
    bit           m_coll, m_wait, m_valid, m_ferr, m_ovr, m_par;
    logic [W-1:0] m_dm, m_dl;
    logic [W-1:0] exp_q[$];   // words expected at the MSB-first port, in delivery order

    always @(posedge clk) begin
        if (!rst_n) begin
            q_bits.delete();
            m_coll = 0; m_wait = 0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_par = 0;
            m_dm = '0; m_dl = '0;
        end else begin
            bit full;
            full   = 0;
            m_ferr = 0;
            if (m_coll) begin
                if (!s_frame) begin
                    q_bits.delete();
                    m_coll = 0;
                    m_ferr = 1;
                end else if (s_bit_en) begin
                    q_bits.push_back(s_data);
                end
            end else if (m_wait) begin
                if (!s_frame) m_wait = 0;
            end else if (s_frame && s_bit_en) begin
                q_bits.push_back(s_data);
                m_coll = 1;
            end
            if (m_coll && q_bits.size() == NB) begin
                full   = 1;
                m_coll = 0;
                m_wait = 1;
            end
            if (full) begin
                if (!m_valid || par_ready) begin
                    m_valid = 1;
                    for (int i = 0; i < W; i++) begin
                        m_dm[W-1-i] = q_bits[i];
                        m_dl[i]     = q_bits[i];
                    end
                    m_par = 0;
`ifdef S2P_PARITY_EN
                    foreach (q_bits[i]) m_par ^= q_bits[i];
`endif
                    exp_q.push_back(m_dm);
                end else begin
                    m_ovr = 1;
                end
                q_bits.delete();
            end else if (m_valid && par_ready) begin
                m_valid = 0;
            end
        end
    end

    // Compare both DUTs against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_msb", valid_m, m_valid);
            check("valid_lsb", valid_l, m_valid);
            check("data_msb", data_m, m_dm);
            check("data_lsb", data_l, m_dl);
            check("busy_msb", busy_m, m_coll | m_wait);
            check("busy_lsb", busy_l, m_coll | m_wait);
            check("ferr_msb", ferr_m, m_ferr);
            check("ferr_lsb", ferr_l, m_ferr);
            check("ovr_msb", ovr_m, m_ovr);
            check("ovr_lsb", ovr_l, m_ovr);
            check("perr_msb", perr_m, m_par);
            check("perr_lsb", perr_l, m_par);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        if (rand_ready) par_ready = 1'($urandom_range(0, 1));
    endtask

    // Element i is the i-th bit on the wire; element W is the parity bit
    function automatic logic [63:0] make_seq(input logic [W-1:0] w, input bit msb_order,
                                             input bit pbit);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < W; i++) s[i] = msb_order ? w[W-1-i] : w[i];
        s[W] = pbit;
        return s;
    endfunction

    task automatic send_bits(input logic [63:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            s_frame = 1'b1;
            repeat ($urandom_range(0, gap_max)) tick();
            s_bit_en = 1'b1;
            s_data   = seq[i];
            tick();
            s_bit_en = 1'b0;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit msb_order, input bit pbit);
        send_bits(make_seq(w, msb_order, pbit), NB);
    endtask

    // Drop the frame, sometimes with a stray strobe that must be ignored
    task automatic end_frame();
        s_frame  = 1'b0;
        s_bit_en = 1'($urandom_range(0, 1));
        s_data   = 1'($urandom_range(0, 1));
        tick();
        s_bit_en = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        logic [63:0]  seq;
        int           kind, n;

        rst_n = 1'b0; s_frame = 1'b0; s_bit_en = 1'b0; s_data = 1'b0; par_ready = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_valid", valid_m, 0);
        check("rst_data", data_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_overrun", ovr_m, 0);
        check("rst_state", st_m, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // 1: A5A5A5A5 MSB-first with ready high
        par_ready = 1'b1;
        send_word(32'hA5A5A5A5, 1'b1, ^(32'hA5A5A5A5));
        check("t1_valid", valid_m, 1);
        check("t1_data_msb", data_m, 32'hA5A5A5A5);
        check("t1_data_lsb", data_l, 32'hA5A5A5A5);
        tick();
        check("t1_valid_drop", valid_m, 0);
        end_frame();
        check("t1_busy_low", busy_m, 0);

        // 2: 01234567 LSB-first; the MSB-first receiver sees its bit reversal
        send_word(32'h01234567, 1'b0, ^(32'h01234567));
        check("t2_data_lsb", data_l, 32'h01234567);
        check("t2_data_msb", data_m, 32'hE6A2C480);
        end_frame();

        // 3: frame dropped after 17 bits, then a clean frame
        send_bits(make_seq(32'h5A5A5A5A, 1'b1, 1'b0), 17);
        end_frame();
        check("t3_ferr", ferr_m, 1);
        check("t3_state", st_m, ST_IDLE);
        check("t3_valid", valid_m, 0);
        tick();
        check("t3_ferr_pulse", ferr_m, 0);
        send_word(32'h5A5A5A5A, 1'b1, ^(32'h5A5A5A5A));
        check("t3_data", data_m, 32'h5A5A5A5A);
        end_frame();

        // 4: consumer stalled, second word overruns
        par_ready = 1'b0;
        send_word(32'h76543210, 1'b1, ^(32'h76543210));
        end_frame();
        send_word(32'hFFFFFFFF, 1'b1, 1'b0);
        check("t4_data_held", data_m, 32'h76543210);
        check("t4_overrun", ovr_m, 1);
        end_frame();
        par_ready = 1'b1;
        tick();
        check("t4_valid_drop", valid_m, 0);
        check("t4_overrun_sticky", ovr_m, 1);

        // 5: reset mid-frame, then a fresh frame
        send_bits(make_seq(32'hDEADBEEF, 1'b1, 1'b0), 10);
        rst_n = 1'b0;
        tick();
        check("t5_valid", valid_m, 0);
        check("t5_data", data_m, 0);
        check("t5_busy", busy_m, 0);
        check("t5_overrun", ovr_m, 0);
        check("t5_state", st_m, ST_IDLE);
        rst_n = 1'b1;
        s_frame = 1'b0;
        tick();
        send_word(32'h000000FF, 1'b1, ^(32'h000000FF));
        check("t5_data_new", data_m, 32'h000000FF);
        end_frame();

`ifdef S2P_PARITY_EN
        // 6: parity bit correct, then wrong; data delivered either way
        send_word(32'hA5A5A5A5, 1'b1, 1'b0);
        check("t6_perr0", perr_m, 0);
        end_frame();
        send_word(32'hA5A5A5A5, 1'b1, 1'b1);
        check("t6_perr1", perr_m, 1);
        check("t6_data", data_m, 32'hA5A5A5A5);
        end_frame();
`endif

        // Randomized frames: random words, order, parity, ready, aborts and resets
        gap_max    = 2;
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            w    = $urandom;
            seq  = make_seq(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                n = $urandom_range(1, NB - 1);
                send_bits(seq, n);
                end_frame();
            end else if (kind == 1) begin
                n = $urandom_range(1, NB - 1);
                send_bits(seq, n);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                end_frame();
            end else begin
                send_bits(seq, NB);
                repeat ($urandom_range(0, 2)) begin
                    s_bit_en = 1'($urandom_range(0, 1));
                    s_data   = 1'($urandom_range(0, 1));
                    tick();
                end
                s_bit_en = 1'b0;
                end_frame();
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        par_ready  = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
